// File: rtl/jogo_seq_unidade_controle_pkg.sv
// Shared definitions for the sequence-game control unit: state codes (also the
// debug/7-seg codes seen on db_estado) and the Moore output bundle.
package jogo_seq_unidade_controle_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hB,
        FIM_TIMEOUT = 4'hC
    } estado_t;

    localparam logic [3:0] DB_INVALIDO = 4'hF;

    typedef struct packed {
        logic zeraC;
        logic contaC;
        logic zeraR;
        logic registraR;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } saidas_t;

    localparam saidas_t SAIDAS_NULAS = '{default: 1'b0};

    function automatic logic eh_estado_final(input estado_t e);
        return (e == FIM_ACERTO) || (e == FIM_ERRO) || (e == FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/jogo_seq_unidade_controle_if.sv
// Control/status bundle between the control unit (master) and the game
// datapath (slave): play pulse, counter/comparator status and control strobes.
interface jogo_seq_unidade_controle_if;

    logic jogada;
    logic fimC;
    logic igual;
    logic zeraC;
    logic contaC;
    logic zeraR;
    logic registraR;

    modport master (
        input  jogada,
        input  fimC,
        input  igual,
        output zeraC,
        output contaC,
        output zeraR,
        output registraR
    );

    modport slave (
        output jogada,
        output fimC,
        output igual,
        input  zeraC,
        input  contaC,
        input  zeraR,
        input  registraR
    );

endinterface

// File: rtl/jogo_seq_unidade_controle_contador_timeout.sv
// Play-timeout counter: synchronous clear, enable, asynchronous reset, and a
// terminal-count flag; it saturates at the terminal count instead of wrapping.
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int TW             = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa_i,
    input  logic habilita_i,
    output logic fim_o
);

    localparam logic [TW-1:0] TERMINAL = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [TW-1:0] UM       = TW'(1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // next count: clear wins, then count up to the terminal value and stop
    always_comb begin
        cnt_d = cnt_q;
        if (limpa_i) begin
            cnt_d = '0;
        end else if (habilita_i && (cnt_q != TERMINAL)) begin
            cnt_d = cnt_q + UM;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign fim_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/jogo_seq_unidade_controle.sv
// Moore control unit for the sequence-checking game: waits for each play,
// registers and compares it, advances the address, and ends in hit/miss/timeout.
module jogo_seq_unidade_controle
    import jogo_seq_unidade_controle_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int TW             = 13
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              iniciar,
    jogo_seq_unidade_controle_if.master       dp,
    output logic                              pronto,
    output logic                              acertou,
    output logic                              errou,
    output logic                              timeout,
    output logic [3:0]                        db_estado
);

    estado_t estado_q;
    estado_t estado_d;
    saidas_t saidas_s;
    logic [3:0] db_estado_s;
    logic tmo_fim_s;
    logic em_espera_s;

    assign em_espera_s = (estado_q == ESPERA);

    // The counter only runs while waiting, so every play gets a fresh window.
    contador_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .TW             (TW)
    ) u_contador_timeout (
        .clock      (clock),
        .reset      (reset),
        .limpa_i    (!em_espera_s),
        .habilita_i (em_espera_s),
        .fim_o      (tmo_fim_s)
    );

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // next-state logic; a play arriving on the terminal count beats the timeout
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
                else         estado_d = INICIAL;
            end
            PREPARACAO: estado_d = ESPERA;
            ESPERA: begin
                if (dp.jogada)      estado_d = REGISTRA;
                else if (tmo_fim_s) estado_d = FIM_TIMEOUT;
                else                estado_d = ESPERA;
            end
            REGISTRA: estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!dp.igual)    estado_d = FIM_ERRO;
                else if (dp.fimC) estado_d = FIM_ACERTO;
                else              estado_d = PROXIMO;
            end
            PROXIMO: estado_d = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARACAO;
                else         estado_d = estado_q;
            end
            default: estado_d = INICIAL;
        endcase
    end

    // Moore output decode from the current state only
    always_comb begin
        saidas_s    = SAIDAS_NULAS;
        db_estado_s = DB_INVALIDO;
        case (estado_q)
            INICIAL, PREPARACAO: begin
                saidas_s.zeraC = 1'b1;
                saidas_s.zeraR = 1'b1;
                db_estado_s    = estado_q;
            end
            ESPERA, COMPARACAO: begin
                db_estado_s = estado_q;
            end
            REGISTRA: begin
                saidas_s.registraR = 1'b1;
                db_estado_s        = estado_q;
            end
            PROXIMO: begin
                saidas_s.contaC = 1'b1;
                db_estado_s     = estado_q;
            end
            FIM_ACERTO: begin
                saidas_s.acertou = 1'b1;
                db_estado_s      = estado_q;
            end
            FIM_ERRO: begin
                saidas_s.errou = 1'b1;
                db_estado_s    = estado_q;
            end
            FIM_TIMEOUT: begin
                saidas_s.timeout = 1'b1;
                db_estado_s      = estado_q;
            end
            default: begin
                saidas_s    = SAIDAS_NULAS;
                db_estado_s = DB_INVALIDO;
            end
        endcase
        saidas_s.pronto = eh_estado_final(estado_q);
    end

    assign dp.zeraC     = saidas_s.zeraC;
    assign dp.contaC    = saidas_s.contaC;
    assign dp.zeraR     = saidas_s.zeraR;
    assign dp.registraR = saidas_s.registraR;
    assign pronto       = saidas_s.pronto;
    assign acertou      = saidas_s.acertou;
    assign errou        = saidas_s.errou;
    assign timeout      = saidas_s.timeout;
    assign db_estado    = db_estado_s;

endmodule
